// File: rtl/multdiv_sequencer.sv
// Execute-stage sequencer for R-type mul/div: detects the instruction, pulses the
// multdiv start line, stalls until result or timeout, then strobes write-back.
module multdiv_sequencer #(
  parameter int unsigned TIMEOUT = 40
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] opcode,
  input  logic [4:0] alu_op,
  input  logic       x_valid,
  input  logic       md_ready,
  input  logic       md_exception,
  output logic       ctrl_MULT,
  output logic       ctrl_DIV,
  output logic       stall,
  output logic       wb_en,
  output logic       rstatus_wr,
  output logic [2:0] rstatus_code,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [5:0] CNT_LAST = 6'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       op_div_q, op_div_d;
  logic       exc_q, exc_d;
  logic       tmo_q, tmo_d;

  logic is_mul, is_div, is_md;

  assign is_mul = x_valid & (opcode == 5'b00000) & (alu_op == 5'b00110);
  assign is_div = x_valid & (opcode == 5'b00000) & (alu_op == 5'b00111);
  assign is_md  = is_mul | is_div;

  // State and sequence bookkeeping registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      op_div_q <= 1'b0;
      exc_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_div_q <= op_div_d;
      exc_q    <= exc_d;
      tmo_q    <= tmo_d;
    end
  end

  // Next-state logic; md_ready is only looked at in WAIT
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_div_d = op_div_q;
    exc_d    = exc_q;
    tmo_d    = tmo_q;
    case (state_q)
      IDLE: begin
        if (is_md) begin
          state_d  = START;
          op_div_d = is_div;
          exc_d    = 1'b0;
          tmo_d    = 1'b0;
        end else begin
          state_d  = IDLE;
        end
      end
      START: begin
        cnt_d   = 6'd0;
        state_d = WAIT;
      end
      WAIT: begin
        if (md_ready) begin
          exc_d   = md_exception;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          tmo_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + 6'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode; stall is the only output that also depends on inputs
  always_comb begin
    ctrl_MULT    = 1'b0;
    ctrl_DIV     = 1'b0;
    stall        = 1'b0;
    wb_en        = 1'b0;
    rstatus_wr   = 1'b0;
    rstatus_code = 3'd0;
    busy         = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        stall = is_md;
      end
      START: begin
        stall     = 1'b1;
        ctrl_MULT = ~op_div_q;
        ctrl_DIV  = op_div_q;
      end
      WAIT: begin
        stall = 1'b1;
      end
      DONE: begin
        wb_en      = 1'b1;
        rstatus_wr = exc_q | tmo_q;
        if (!(exc_q | tmo_q)) begin
          rstatus_code = 3'd0;
        end else if (tmo_q) begin
          rstatus_code = 3'd7;
        end else if (op_div_q) begin
          rstatus_code = 3'd5;
        end else begin
          rstatus_code = 3'd4;
        end
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/multdiv_sequencer.md
# multdiv_sequencer

Sequences the multicycle multiplier/divider for R-type `mul` and `div` instructions sitting in the execute stage. It detects the instruction, issues the one-cycle start pulse to the multdiv unit and holds the pipeline stalled until the result is ready or a timeout expires. It then releases the pipeline with a one-cycle result-write strobe and an optional `$rstatus` write request. It sits between the X-stage instruction latch, the opcode decode logic and the multdiv unit.

## Interface
- `TIMEOUT`, default 40: maximum WAIT cycles before a forced abort; legal range 2..63.
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high.
- `opcode` in 5: X-stage instruction opcode field.
- `alu_op` in 5: X-stage ALU op field.
- `x_valid` in 1: X stage holds a valid (non-bubble) instruction.
- `md_ready` in 1: multdiv result valid.
- `md_exception` in 1: multdiv overflow or divide-by-zero; meaningful only when `md_ready`=1.
- `ctrl_MULT` out 1: one-cycle start pulse to the multiplier.
- `ctrl_DIV` out 1: one-cycle start pulse to the divider.
- `stall` out 1: freezes PC, F/D and D/X latches and the X-stage instruction.
- `wb_en` out 1: one-cycle strobe; X/M latch captures the multdiv result.
- `rstatus_wr` out 1: one-cycle request to write `$rstatus` (r30).
- `rstatus_code` out 3: value for `$rstatus` (4 = mul exception, 5 = div exception, 7 = timeout); 0 when `rstatus_wr`=0.
- `busy` out 1: state is not IDLE.

## Operation
- Decode rule:
  - `is_mul` = `x_valid` & `opcode`==00000 & `alu_op`==00110.
  - `is_div` = `x_valid` & `opcode`==00000 & `alu_op`==00111.
  - `is_md` = `is_mul` | `is_div`.
- Internal registers: 2-bit state, 6-bit `cnt`, `op_div` flag (latched at detect), `exc` flag, `tmo` flag.
- States:
  - **IDLE**: if `is_md`, latch `op_div` = `is_div`, clear `exc`/`tmo`, go to START; otherwise stay.
  - **START**: assert `ctrl_MULT` (if !`op_div`) or `ctrl_DIV` (if `op_div`); clear `cnt`; go to WAIT.
  - **WAIT**:
    - If `md_ready`: latch `exc` = `md_exception`, go to DONE.
    - Else if `cnt` == `TIMEOUT`-1: set `tmo`, go to DONE.
    - Else `cnt` += 1.
  - **DONE**: assert `wb_en`; assert `rstatus_wr` if `exc` | `tmo`; go to IDLE.
- Output equations:
  - `stall` = (IDLE & `is_md`) | START | WAIT. This is the only combinational path from inputs; it must be asserted in the detect cycle so the instruction does not leave X.
  - `stall` = 0 in DONE, so the pipeline advances the same cycle `wb_en` is high.
  - `rstatus_code` = 7 if `tmo`; else 5 if `op_div`; else 4. It is gated to 0 when `rstatus_wr`=0.
  - `ctrl_MULT`, `ctrl_DIV`, `wb_en`, `rstatus_wr`, `rstatus_code` and `busy` are decoded from registered state only.
- Boundary conditions:
  - `md_ready` is ignored in IDLE, START and DONE.
  - `md_ready` and timeout in the same WAIT cycle: `md_ready` wins; `tmo` stays 0.
  - Back-to-back `mul`/`div`: in the IDLE cycle after DONE the next X instruction is decoded normally. Minimum spacing is 3 cycles plus multdiv latency.
  - `is_md` deasserting after detect (e.g. `x_valid` glitch) does not abort the sequence.
  - Reset mid-operation:
    - State goes to IDLE.
    - All outputs and internal registers go to 0 asynchronously.
    - No start pulse, `wb_en` or `rstatus_wr` is emitted afterwards.

## Timing
- Reset values: every output is 0; state is IDLE; `cnt`, `op_div`, `exc` and `tmo` are 0.
- Cycle-level sequence, with cycle 0 the detect cycle:
  - Cycle 0: IDLE, `stall`=1.
  - Cycle 1: START, start pulse high, `stall`=1.
  - Cycles 2..k: WAIT, `stall`=1.
  - Cycle k+1: DONE, `wb_en`=1, `stall`=0.
  - Here k is the cycle in which `md_ready` is first sampled high in WAIT.
- Total stall cycles = k+1. With `md_ready` high in the first WAIT cycle (k=2), the instruction stalls 3 cycles.
- Timeout: DONE occurs at cycle `TIMEOUT`+2 if `md_ready` never rises; the stall lasts `TIMEOUT`+2 cycles.
- Start pulses, `wb_en` and `rstatus_wr` are each exactly one cycle wide per sequence.

## Test plan
- Reset asserted mid-WAIT (cycle 5), then released: all outputs 0 immediately; no `wb_en` afterwards; `busy`=0.
- `mul`, multdiv returns `md_ready`=1, `md_exception`=0 at cycle 34: `ctrl_MULT` high only at cycle 1; `stall` high cycles 0–34; `wb_en`=1 at cycle 35; `rstatus_wr`=0.
- `div` with `md_exception`=1 at cycle 4: `ctrl_DIV` high only at cycle 1; at cycle 5 `wb_en`=1, `rstatus_wr`=1, `rstatus_code`=5.
- `TIMEOUT`=4, `mul`, `md_ready` never rises: DONE at cycle 6 with `rstatus_code`=7; `stall` high cycles 0–5.
- `md_ready` rises in the same cycle the timeout would fire: `rstatus_code`=4 only if `md_exception`, else `rstatus_wr`=0.
- Two consecutive `mul` instructions, each with `md_ready` at its first WAIT cycle: two `ctrl_MULT` pulses 4 cycles apart; two `wb_en` pulses; `addi` (opcode 00101) never triggers `stall`.
